// File: rtl/dac_spi_arbiter.sv
// Round-robin arbiter sharing one DAC SPI master between REQNUM arm/finished requesters, with grant lock.
// Optional watchdog: define DAC_ARB_TIMEOUT_EN.
module dac_spi_arbiter #(
    parameter int REQNUM         = 3,
    parameter int DAC_WID        = 24,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int TIMEOUT_WID    = 13
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [REQNUM-1:0]         req_arm,
    input  logic [REQNUM-1:0]         req_lock,
    input  logic [REQNUM*DAC_WID-1:0] req_to_dac,
    output logic [DAC_WID-1:0]        req_from_dac,
    output logic [REQNUM-1:0]         req_finished,
    output logic [REQNUM-1:0]         grant,
    output logic                      master_arm,
    output logic [DAC_WID-1:0]        master_to_dac,
    input  logic [DAC_WID-1:0]        master_from_dac,
    input  logic                      master_finished,
    output logic                      busy,
    output logic                      timeout_err
);

    localparam int SW = (REQNUM > 1) ? $clog2(REQNUM) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ARM, S_DONE, S_HOLD} state_t;

    state_t              r_state;
    logic [SW-1:0]       r_sel;
    logic [SW-1:0]       r_last;
    logic [REQNUM-1:0]   r_grant;
    logic [REQNUM-1:0]   r_fin;
    logic                r_arm;
    logic [DAC_WID-1:0]  r_to_dac;
    logic [DAC_WID-1:0]  r_from_dac;

    logic                w_found;
    logic [SW-1:0]       w_pick;
    logic [SW:0]         w_idx;
    logic                w_arm_sel;
    logic                w_lock_sel;
    logic [DAC_WID-1:0]  w_to_dac_sel;
    logic [DAC_WID-1:0]  w_to_dac_pick;
    logic [REQNUM-1:0]   w_pick_oh;

    // Walk from farthest to nearest so the first armed requester after r_last wins.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = '0;
        for (int k = REQNUM; k >= 1; k--) begin
            w_idx = {1'b0, r_last} + (SW+1)'(k);
            if (w_idx >= (SW+1)'(REQNUM))
                w_idx = w_idx - (SW+1)'(REQNUM);
            if (req_arm[w_idx[SW-1:0]]) begin
                w_found = 1'b1;
                w_pick  = w_idx[SW-1:0];
            end
        end
    end

    assign w_arm_sel     = req_arm[r_sel];
    assign w_lock_sel    = req_lock[r_sel];
    assign w_to_dac_sel  = req_to_dac[r_sel*DAC_WID +: DAC_WID];
    assign w_to_dac_pick = req_to_dac[w_pick*DAC_WID +: DAC_WID];
    assign w_pick_oh     = {{(REQNUM-1){1'b0}}, 1'b1} << w_pick;

`ifdef DAC_ARB_TIMEOUT_EN
    logic [TIMEOUT_WID-1:0] r_cnt;
    logic                   r_terr;
    localparam logic [TIMEOUT_WID-1:0] TO_LAST = TIMEOUT_WID'(TIMEOUT_CYCLES - 1);
    assign timeout_err = r_terr;
`else
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_sel      <= '0;
            r_last     <= SW'(REQNUM - 1);
            r_grant    <= '0;
            r_fin      <= '0;
            r_arm      <= 1'b0;
            r_to_dac   <= '0;
            r_from_dac <= '0;
`ifdef DAC_ARB_TIMEOUT_EN
            r_cnt      <= '0;
            r_terr     <= 1'b0;
`endif
        end else begin
`ifdef DAC_ARB_TIMEOUT_EN
            // Cleared on every transition; only the stay-put branches count up.
            r_cnt <= '0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (!master_finished && w_found) begin
                        r_sel    <= w_pick;
                        r_grant  <= w_pick_oh;
                        r_to_dac <= w_to_dac_pick;
                        r_arm    <= 1'b1;
                        r_state  <= S_ARM;
                    end
                end
                S_ARM: begin
                    if (master_finished) begin
                        r_from_dac <= master_from_dac;
                        r_arm      <= 1'b0;
                        if (w_arm_sel)
                            r_fin[r_sel] <= 1'b1;
                        r_state    <= S_DONE;
                    end
`ifdef DAC_ARB_TIMEOUT_EN
                    else if (r_cnt == TO_LAST) begin
                        r_arm   <= 1'b0;
                        r_terr  <= 1'b1;
                        r_grant <= '0;
                        r_last  <= r_sel;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
`endif
                end
                S_DONE: begin
                    if (!w_arm_sel) begin
                        r_fin <= '0;
                        if (w_lock_sel) begin
                            r_state <= S_HOLD;
                        end else begin
                            r_grant <= '0;
                            r_last  <= r_sel;
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_HOLD: begin
                    // A dropped lock wins over a new arm in the same cycle.
                    if (!w_lock_sel) begin
                        r_grant <= '0;
                        r_last  <= r_sel;
                        r_state <= S_IDLE;
                    end else if (w_arm_sel && !master_finished) begin
                        r_to_dac <= w_to_dac_sel;
                        r_arm    <= 1'b1;
                        r_state  <= S_ARM;
                    end
`ifdef DAC_ARB_TIMEOUT_EN
                    else if (r_cnt == TO_LAST) begin
                        r_terr  <= 1'b1;
                        r_grant <= '0;
                        r_last  <= r_sel;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
`endif
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign grant         = r_grant;
    assign req_finished  = r_fin;
    assign master_arm    = r_arm;
    assign master_to_dac = r_to_dac;
    assign req_from_dac  = r_from_dac;
    assign busy          = |r_grant;

endmodule
